// File: rtl/parking_slot_ctrl.sv
// parking_slot_ctrl: debounced keypad select/confirm protocol owning a parking-slot occupancy map
module parking_slot_ctrl #(
    parameter int NUM_SLOTS      = 6,
    parameter int DEB_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 press_in,
    input  logic [3:0]           value_in,
    input  logic                 clr_all,
    output logic [NUM_SLOTS-1:0] occupied,
    output logic [3:0]           free_count,
    output logic                 full,
    output logic                 armed,
    output logic [3:0]           armed_slot,
    output logic                 evt_valid,
    output logic                 evt_leave,
    output logic [3:0]           evt_slot,
    output logic                 err_valid,
    output logic [1:0]           err_code
);
    localparam int CW = $clog2(DEB_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [1:0] D_RELEASED    = 2'd0;
    localparam logic [1:0] D_PRESS_CNT   = 2'd1;
    localparam logic [1:0] D_HELD        = 2'd2;
    localparam logic [1:0] D_RELEASE_CNT = 2'd3;
    localparam logic [0:0] S_IDLE        = 1'b0;
    localparam logic [0:0] S_ARMED       = 1'b1;

    logic [1:0]           deb_q, deb_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           key_q, key_d;
    logic                 key_strobe;
    logic [0:0]           st_q, st_d;
    logic [3:0]           slot_q, slot_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [NUM_SLOTS-1:0] occ_q, occ_d, onehot;
    logic [3:0]           free_q, free_d;
    logic                 evt_valid_q, evt_valid_d, evt_leave_q, evt_leave_d;
    logic [3:0]           evt_slot_q, evt_slot_d;
    logic                 err_valid_q, err_valid_d;
    logic [1:0]           err_code_q, err_code_d;
    logic                 key_ok, prior, timeout;

    always_comb begin
        deb_d      = deb_q;
        cnt_d      = cnt_q;
        key_d      = key_q;
        key_strobe = 1'b0;
        case (deb_q)
            D_RELEASED: if (press_in) begin
                deb_d = D_PRESS_CNT;
                key_d = value_in;
                cnt_d = '0;
            end
            D_PRESS_CNT: if (!press_in) begin
                deb_d = D_RELEASED;
            end else if (value_in != key_q) begin
                key_d = value_in;
                cnt_d = '0;
            end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                key_strobe = 1'b1;
                deb_d      = D_HELD;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            D_HELD: if (!press_in) begin
                deb_d = D_RELEASE_CNT;
                cnt_d = '0;
            end
            default: if (press_in) begin
                deb_d = D_HELD;
            end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                deb_d = D_RELEASED;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        endcase
    end

    assign key_ok  = (key_q != 4'd0) && (key_q <= 4'(NUM_SLOTS));
    assign onehot  = NUM_SLOTS'(1) << (key_q - 4'd1);
    assign prior   = |(occ_q & onehot);
    assign timeout = (st_q == S_ARMED) && (timer_q == TW'(TIMEOUT_CYCLES - 1));

    // clr_all outranks everything; a key strobe outranks a same-cycle timeout
    always_comb begin
        st_d        = st_q;
        slot_d      = slot_q;
        timer_d     = (st_q == S_ARMED) ? timer_q + TW'(1) : '0;
        occ_d       = occ_q;
        free_d      = free_q;
        evt_valid_d = 1'b0;
        evt_leave_d = evt_leave_q;
        evt_slot_d  = evt_slot_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        if (clr_all) begin
            st_d    = S_IDLE;
            slot_d  = 4'd0;
            timer_d = '0;
            occ_d   = '0;
            free_d  = 4'(NUM_SLOTS);
        end else if (key_strobe && st_q == S_IDLE) begin
            if (!key_ok) begin
                err_valid_d = 1'b1;
                err_code_d  = 2'b01;
            end else begin
                st_d    = S_ARMED;
                slot_d  = key_q;
                timer_d = '0;
            end
        end else if (key_strobe) begin
            st_d   = S_IDLE;
            slot_d = 4'd0;
            if (key_q == slot_q) begin
                occ_d       = occ_q ^ onehot;
                free_d      = prior ? free_q + 4'd1 : free_q - 4'd1;
                evt_valid_d = 1'b1;
                evt_leave_d = prior;
                evt_slot_d  = key_q;
            end else begin
                err_valid_d = 1'b1;
                err_code_d  = key_ok ? 2'b10 : 2'b01;
            end
        end else if (timeout) begin
            st_d        = S_IDLE;
            slot_d      = 4'd0;
            err_valid_d = 1'b1;
            err_code_d  = 2'b11;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q       <= D_RELEASED;
            cnt_q       <= '0;
            key_q       <= 4'd0;
            st_q        <= S_IDLE;
            slot_q      <= 4'd0;
            timer_q     <= '0;
            occ_q       <= '0;
            free_q      <= 4'(NUM_SLOTS);
            evt_valid_q <= 1'b0;
            evt_leave_q <= 1'b0;
            evt_slot_q  <= 4'd0;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            deb_q       <= deb_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            st_q        <= st_d;
            slot_q      <= slot_d;
            timer_q     <= timer_d;
            occ_q       <= occ_d;
            free_q      <= free_d;
            evt_valid_q <= evt_valid_d;
            evt_leave_q <= evt_leave_d;
            evt_slot_q  <= evt_slot_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign occupied   = occ_q;
    assign free_count = free_q;
    assign full       = (free_q == 4'd0);
    assign armed      = (st_q == S_ARMED);
    assign armed_slot = slot_q;
    assign evt_valid  = evt_valid_q;
    assign evt_leave  = evt_leave_q;
    assign evt_slot   = evt_slot_q;
    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;
endmodule

// File: tb/tb_parking_slot_ctrl.sv
// tb_parking_slot_ctrl: directed checks of debounce, select/confirm protocol, errors, clear and reset
module tb_parking_slot_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       press_in = 1'b0;
    logic [3:0] value_in = 4'd0;
    logic       clr_all = 1'b0;
    logic [5:0] occupied;
    logic [3:0] free_count, armed_slot, evt_slot;
    logic       full, armed, evt_valid, evt_leave, err_valid;
    logic [1:0] err_code;

    int n_chk = 0, n_pass = 0;
    int n_evt = 0, n_err = 0, n_arm = 0;
    logic [3:0] last_slot = 4'd0;
    logic       last_leave = 1'b0, armed_prev = 1'b0;
    logic [1:0] last_err = 2'd0;
    int e0, r0, a0;

    parking_slot_ctrl #(.NUM_SLOTS(6), .DEB_CYCLES(4), .TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .rst_n(rst_n), .press_in(press_in), .value_in(value_in), .clr_all(clr_all),
        .occupied(occupied), .free_count(free_count), .full(full), .armed(armed),
        .armed_slot(armed_slot), .evt_valid(evt_valid), .evt_leave(evt_leave),
        .evt_slot(evt_slot), .err_valid(err_valid), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (evt_valid) begin
            n_evt++;
            last_slot  = evt_slot;
            last_leave = evt_leave;
        end
        if (err_valid) begin
            n_err++;
            last_err = err_code;
        end
        if (armed && !armed_prev) n_arm++;
        armed_prev = armed;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic snap();
        e0 = n_evt;
        r0 = n_err;
        a0 = n_arm;
    endtask

    task automatic key_press(input logic [3:0] v, input int hold, input int rel);
        @(negedge clk);
        press_in = 1'b1;
        value_in = v;
        repeat (hold) @(negedge clk);
        press_in = 1'b0;
        repeat (rel) @(negedge clk);
    endtask

    task automatic park(input logic [3:0] v);
        key_press(v, 6, 6);
        key_press(v, 6, 6);
    endtask

    task automatic glitch(input logic [3:0] v);
        repeat (2) begin
            press_in = 1'b1;
            value_in = v;
            repeat (2) @(negedge clk);
            press_in = 1'b0;
            @(negedge clk);
        end
    endtask

    // returns at the first negedge with armed high, key released
    task automatic arm_wait(input logic [3:0] v);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        press_in = 1'b1;
        value_in = v;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = armed;
        end
        press_in = 1'b0;
        check("arm_wait", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_occ", {26'd0, occupied}, 32'd0);
        check("rst_free", {28'd0, free_count}, 32'd6);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_armed", {31'd0, armed}, 32'd0);

        snap();
        key_press(4'd3, 10, 0);
        check("t1_armed", {31'd0, armed}, 32'd1);
        check("t1_aslot", {28'd0, armed_slot}, 32'd3);
        repeat (6) @(negedge clk);
        key_press(4'd3, 10, 6);
        check("t1_evts", n_evt - e0, 32'd1);
        check("t1_slot", {28'd0, last_slot}, 32'd3);
        check("t1_leave", {31'd0, last_leave}, 32'd0);
        check("t1_occ", {26'd0, occupied}, 32'h04);
        check("t1_free", {28'd0, free_count}, 32'd5);
        check("t1_errs", n_err - r0, 32'd0);

        snap();
        @(negedge clk);
        glitch(4'd3);
        press_in = 1'b1;
        value_in = 4'd3;
        repeat (6) @(negedge clk);
        press_in = 1'b0;
        repeat (5) @(negedge clk);
        check("t2_arm_once", n_arm - a0, 32'd1);
        glitch(4'd3);
        press_in = 1'b1;
        repeat (6) @(negedge clk);
        press_in = 1'b0;
        repeat (6) @(negedge clk);
        check("t2_evts", n_evt - e0, 32'd1);
        check("t2_arms", n_arm - a0, 32'd1);
        check("t2_leave", {31'd0, last_leave}, 32'd1);
        check("t2_occ", {26'd0, occupied}, 32'd0);
        check("t2_free", {28'd0, free_count}, 32'd6);
        check("t2_errs", n_err - r0, 32'd0);

        snap();
        key_press(4'd7, 6, 6);
        check("t3_inv_err", n_err - r0, 32'd1);
        check("t3_inv_code", {30'd0, last_err}, 32'd1);
        check("t3_inv_idle", {31'd0, armed}, 32'd0);
        key_press(4'd2, 6, 6);
        key_press(4'd5, 6, 6);
        check("t3_mis_err", n_err - r0, 32'd2);
        check("t3_mis_code", {30'd0, last_err}, 32'd2);
        check("t3_mis_idle", {31'd0, armed}, 32'd0);
        arm_wait(4'd4);
        n = 0;
        while (n < 40 && !err_valid) begin
            @(negedge clk);
            n++;
        end
        check("t3_to_cycles", n, 32'd20);
        check("t3_to_code", {30'd0, err_code}, 32'd3);
        check("t3_to_idle", {31'd0, armed}, 32'd0);
        check("t3_evts", n_evt - e0, 32'd0);
        repeat (6) @(negedge clk);

        for (int k = 1; k <= 6; k++) begin
            park(4'(k));
            check("t4_free", {28'd0, free_count}, 32'(6 - k));
            check("t4_full", {31'd0, full}, (k == 6) ? 32'd1 : 32'd0);
        end
        check("t4_occ", {26'd0, occupied}, 32'h3f);
        snap();
        park(4'd2);
        check("t4_leave", {31'd0, last_leave}, 32'd1);
        check("t4_lv_full", {31'd0, full}, 32'd0);
        check("t4_lv_free", {28'd0, free_count}, 32'd1);
        check("t4_lv_occ", {26'd0, occupied}, 32'h3d);

        snap();
        arm_wait(4'd2);
        repeat (15) @(negedge clk);
        press_in = 1'b1;
        value_in = 4'd2;
        repeat (6) @(negedge clk);
        press_in = 1'b0;
        repeat (8) @(negedge clk);
        check("t5_pri_evt", n_evt - e0, 32'd1);
        check("t5_pri_err", n_err - r0, 32'd0);
        check("t5_pri_slot", {28'd0, last_slot}, 32'd2);
        check("t5_pri_occ", {26'd0, occupied}, 32'h3f);

        clr_all = 1'b1;
        @(negedge clk);
        clr_all = 1'b0;
        check("t5_clr0_occ", {26'd0, occupied}, 32'd0);
        park(4'd1);
        park(4'd3);
        check("t5_occ5", {26'd0, occupied}, 32'h05);
        arm_wait(4'd2);
        snap();
        clr_all = 1'b1;
        @(negedge clk);
        clr_all = 1'b0;
        check("t5_clr_occ", {26'd0, occupied}, 32'd0);
        check("t5_clr_free", {28'd0, free_count}, 32'd6);
        check("t5_clr_armed", {31'd0, armed}, 32'd0);
        check("t5_clr_aslot", {28'd0, armed_slot}, 32'd0);
        repeat (25) @(negedge clk);
        check("t5_clr_evt", n_evt - e0, 32'd0);
        check("t5_clr_err", n_err - r0, 32'd0);

        park(4'd1);
        arm_wait(4'd3);
        repeat (6) @(negedge clk);
        press_in = 1'b1;
        value_in = 4'd5;
        repeat (2) @(negedge clk);
        snap();
        rst_n = 1'b0;
        #1;
        check("t5_rst_occ", {26'd0, occupied}, 32'd0);
        check("t5_rst_free", {28'd0, free_count}, 32'd6);
        check("t5_rst_armed", {31'd0, armed}, 32'd0);
        check("t5_rst_aslot", {28'd0, armed_slot}, 32'd0);
        @(negedge clk);
        press_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t5_rst_idle", {31'd0, armed}, 32'd0);
        check("t5_rst_pulses", (n_evt - e0) + (n_err - r0), 32'd0);

        snap();
        @(negedge clk);
        press_in = 1'b1;
        value_in = 4'd1;
        repeat (100) @(negedge clk);
        value_in = 4'd2;
        repeat (100) @(negedge clk);
        press_in = 1'b0;
        repeat (8) @(negedge clk);
        check("t6_arms", n_arm - a0, 32'd1);
        check("t6_evts", n_evt - e0, 32'd0);
        check("t6_errs", n_err - r0, 32'd1);
        check("t6_code", {30'd0, last_err}, 32'd3);
        check("t6_occ", {26'd0, occupied}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
